// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-RAM request/response, redirect from the
// core, and the valid/ready instruction hand-off to the core.
//   master : the fetch unit (drives imem_req/imem_addr and out_*)
//   slave  : the environment (RAM + core)
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a synchronous-read
// instruction RAM, buffers {inst, pc} in a DEPTH-entry prefetch FIFO and hands
// the head to the core over valid/ready. A redirect flushes and restarts fetch.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus (master)  imem_req/imem_addr/imem_rdata, redirect/redirect_pc,
//                 out_valid/out_ready/out_inst/out_pc
//   perf_fetched  pops accepted by the core        (FETCH_PERF_EN only)
//   perf_flushed  entries discarded by redirects   (FETCH_PERF_EN only)
//
// Build option: define FETCH_PERF_EN to add the two performance counters.
// imem_req/imem_addr and the out_* payload are combinational from state.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_flushed
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]       inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;

    logic redir;
    logic head_valid;
    logic issue;
    logic push;
    logic pop;

    // Handshake decode and combinational bus outputs
    always_comb begin
        redir      = bus.redirect && !rst;
        head_valid = !rst && (count_q != '0);
        // Outstanding response already owns a slot; same-cycle pop is not credited.
        issue      = redir ||
                     (!rst && ((SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(DEPTH)));
        push       = inflight_q && !redir;
        pop        = head_valid && bus.out_ready && !redir;

        bus.imem_req  = issue;
        bus.imem_addr = rst ? RESET_PC : (redir ? bus.redirect_pc : pc_q);
        bus.out_valid = head_valid;
        bus.out_inst  = head_valid ? inst_mem_q[head_q] : 32'd0;
        bus.out_pc    = head_valid ? pc_mem_q[head_q]   : '0;
    end

    // Next-state for PC, in-flight tracking and FIFO bookkeeping
    always_comb begin
        pc_d       = pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        inflight_d = issue;
        infl_pc_d  = infl_pc_q;

        if (issue) begin
            pc_d      = bus.imem_addr + ADDR_W'(1);
            infl_pc_d = bus.imem_addr;
        end

        if (redir) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)  head_d = head_q + PTR_W'(1);
            if (push) tail_d = tail_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            infl_pc_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            infl_pc_q  <= infl_pc_d;
        end
    end

    // FIFO payload storage; validity is tracked by count_q, so no reset needed
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            inst_mem_q[tail_q] <= bus.imem_rdata;
            pc_mem_q[tail_q]   <= infl_pc_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] flushed_q;

    // A redirect discards the buffered entries plus a killed response
    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= 32'd0;
            flushed_q <= 32'd0;
        end else begin
            if (pop)   fetched_q <= fetched_q + 32'd1;
            if (redir) flushed_q <= flushed_q + 32'(count_q) + 32'(inflight_q);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan scenarios followed by
// randomized ready/redirect/reset traffic, checked every cycle against a
// queue-based reference model of the fetch stage.
module tb_fetch_unit;
    localparam int unsigned       ADDR_W   = 12;
    localparam int unsigned       DEPTH    = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;
    localparam int                PC_MOD   = 1 << ADDR_W;

    typedef struct packed {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
    } ent_t;

    logic clk;
    logic rst;

    fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.master)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction RAM: word k holds 0x1000_0000 + k
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= 32'h1000_0000 + 32'(bus.imem_addr);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // A push into a full FIFO must never happen
    always @(posedge clk) begin
        if (!rst && dut.push) begin
            check("push_not_full", 64'(int'(dut.count_q) < int'(DEPTH)), 64'd1);
            assert (int'(dut.count_q) < int'(DEPTH))
                else $error("FAIL push_full: push into full FIFO");
        end
    end

    // ---------------- reference model ----------------
    ent_t        m_q[$];
    bit          m_infl;
    int          m_ipc;
    int          m_pc;
    logic [31:0] m_fetched;
    logic [31:0] m_flushed;

    function automatic logic [31:0] ram_word(input int a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    task automatic model_step(input bit r, input bit rd, input int rp, input bit rdy);
        int a;
        bit iss;
        ent_t e;
        if (r) begin
            m_q.delete();
            m_infl    = 1'b0;
            m_pc      = int'(RESET_PC);
            m_fetched = 32'd0;
            m_flushed = 32'd0;
        end else begin
            a   = rd ? rp : m_pc;
            iss = rd || (m_q.size() + int'(m_infl) < int'(DEPTH));
            if (rd) begin
                m_flushed = m_flushed + 32'(m_q.size() + int'(m_infl));
                m_q.delete();
            end else begin
                if (m_q.size() > 0 && rdy) begin
                    void'(m_q.pop_front());
                    m_fetched = m_fetched + 32'd1;
                end
                if (m_infl) begin
                    e.inst = ram_word(m_ipc);
                    e.pc   = ADDR_W'(m_ipc);
                    m_q.push_back(e);
                end
            end
            m_infl = iss;
            if (iss) begin
                m_ipc = a;
                m_pc  = (a + 1) % PC_MOD;
            end
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model
    task automatic cycle(input bit r, input bit rd, input int rp, input bit rdy);
        bit          e_valid;
        logic [31:0] e_inst;
        int          e_pc;
        bit          e_req;
        int          e_addr;
        @(negedge clk);
        rst             = r;
        bus.redirect    = rd;
        bus.redirect_pc = ADDR_W'(rp);
        bus.out_ready   = rdy;
        #1;
        e_valid = !r && (m_q.size() > 0);
        e_inst  = e_valid ? m_q[0].inst : 32'd0;
        e_pc    = e_valid ? int'(m_q[0].pc) : 0;
        e_req   = !r && (rd || (m_q.size() + int'(m_infl) < int'(DEPTH)));
        e_addr  = r ? int'(RESET_PC) : (rd ? rp : m_pc);
        check("out_valid", 64'(bus.out_valid), 64'(e_valid));
        check("out_inst",  64'(bus.out_inst),  64'(e_inst));
        check("out_pc",    64'(bus.out_pc),    64'(e_pc));
        check("imem_req",  64'(bus.imem_req),  64'(e_req));
        check("imem_addr", 64'(bus.imem_addr), 64'(e_addr));
`ifdef FETCH_PERF_EN
        check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
        check("perf_flushed", 64'(perf_flushed), 64'(m_flushed));
`endif
        model_step(r, rd, rp, rdy);
    endtask

    int req_cnt;

    initial begin
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b0;
        bus.imem_rdata  = 32'd0;
        m_q.delete();
        m_infl    = 1'b0;
        m_ipc     = 0;
        m_pc      = int'(RESET_PC);
        m_fetched = 32'd0;
        m_flushed = 32'd0;

        // Reset
        repeat (3) cycle(1, 0, 0, 0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_imem_req",  64'(bus.imem_req),  64'd0);
        check("rst_imem_addr", 64'(bus.imem_addr), 64'(RESET_PC));

        // Streaming after reset: request RESET_PC now, output 2 cycles later
        cycle(0, 0, 0, 1);
        check("first_req_addr", 64'(bus.imem_addr), 64'(RESET_PC));
        cycle(0, 0, 0, 1);
        check("lat_not_yet", 64'(bus.out_valid), 64'd0);
        cycle(0, 0, 0, 1);
        check("lat_valid", 64'(bus.out_valid), 64'd1);
        check("lat_pc",    64'(bus.out_pc),    64'(RESET_PC));
        check("lat_inst",  64'(bus.out_inst),  64'h1000_0000);
        cycle(0, 0, 0, 1);
        check("stream_pc1", 64'(bus.out_pc), 64'd1);
        repeat (16) cycle(0, 0, 0, 1);

        // Back-pressure: requests stop once count + inflight reaches DEPTH
        req_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0);
            if (i >= 4) check("stall_no_req", 64'(bus.imem_req), 64'd0);
            req_cnt += int'(bus.imem_req);
        end
        repeat (12) cycle(0, 0, 0, 1);

        // Redirect with 3 buffered + 1 in flight
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 'h200, 0);
        cycle(0, 0, 0, 1);
        check("redir_bubble", 64'(bus.out_valid), 64'd0);
`ifdef FETCH_PERF_EN
        check("redir_flushed", 64'(perf_flushed), 64'd4);
`endif
        cycle(0, 0, 0, 1);
        check("redir_first_pc", 64'(bus.out_pc), 64'h200);
        repeat (6) cycle(0, 0, 0, 1);

        // PC wrap at 2^ADDR_W
        cycle(0, 1, 'hFFE, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("wrap_pc0", 64'(bus.out_pc), 64'hFFE);
        cycle(0, 0, 0, 1);
        check("wrap_pc1", 64'(bus.out_pc), 64'hFFF);
        cycle(0, 0, 0, 1);
        check("wrap_pc2", 64'(bus.out_pc), 64'h000);
        cycle(0, 0, 0, 1);
        check("wrap_pc3", 64'(bus.out_pc), 64'h001);

        // Redirect together with an accepted head: head is not consumed
        cycle(0, 1, 'h040, 1);
        repeat (4) cycle(0, 0, 0, 1);

        // Mid-stream reset with a full FIFO
        repeat (8) cycle(0, 0, 0, 0);
        cycle(1, 1, 'h123, 1);
        check("midrst_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_inst",  64'(bus.out_inst),  64'd0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("midrst_first_pc", 64'(bus.out_pc),    64'(RESET_PC));
        check("midrst_valid2",   64'(bus.out_valid), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 15) == 0),
                  int'($urandom_range(0, PC_MOD - 1)),
                  ($urandom_range(0, 3) != 0));
        end

        check("stall_req_count", 64'(req_cnt), 64'd2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the execute/writeback core. It owns the program counter, issues word-address reads to a synchronous-read instruction RAM, and buffers returned instructions with their PCs in a small prefetch FIFO. It presents them to the core over a valid/ready handshake and flushes on a redirect from the core.

## Interface
- `ADDR_W`, 12: word-address width; the PC wraps modulo 2^ADDR_W.
- `DEPTH`, 4: prefetch FIFO entries; power of two, ≥4.
- `RESET_PC`, 0: PC loaded on reset.

- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req`  out  1  read request; address is sampled by the RAM at the end of this cycle.
- `imem_addr`  out  ADDR_W  word address of the request.
- `imem_rdata`  in  32  read data, valid the cycle after the request.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_W  new fetch address.
- `out_valid`  out  1  FIFO head holds an instruction.
- `out_ready`  in  1  core accepts the head this cycle.
- `out_inst`  out  32  head instruction; 0 when `out_valid`=0.
- `out_pc`  out  ADDR_W  PC of `out_inst`; 0 when `out_valid`=0.
- `perf_fetched`, `perf_flushed`  out  32 each  present only with `FETCH_PERF_EN`.

## Operation
- State: `pc`, FIFO (`DEPTH` × {inst, pc}), `count` (0..DEPTH), one in-flight flag `inflight` and its PC.
- `imem_addr` = `redirect ? redirect_pc : pc` (combinational).
- `imem_req` = `!rst && (redirect || count + inflight < DEPTH)`. `out_ready` in the same cycle is not counted as freeing space.
- On issue: `inflight` is set with the request PC. `pc` advances to request address + 1, wrapping from 2^ADDR_W−1 to 0.
- Cycle after issue: `imem_rdata` and the in-flight PC are pushed to the FIFO tail unless killed.
- Pop: when `out_valid && out_ready && !redirect`.
- A push and a pop in the same cycle leave `count` unchanged.
- Redirect, which has priority over everything:
  - FIFO is emptied (`count`←0).
  - Any response returning in the redirect cycle is discarded.
  - A transfer offered in that cycle does not count as accepted.
  - A new request for `redirect_pc` issues in the same cycle, and `pc`←`redirect_pc`+1.
- Reset:
  - `pc`←RESET_PC, `count`←0, `inflight`←0.
  - Outputs: `out_valid`=0, `out_inst`=0, `out_pc`=0, `imem_req`=0, `imem_addr`=RESET_PC.
  - `redirect` is ignored while `rst`=1.
  - Reset asserted mid-stream discards FIFO contents and any in-flight response.
- FIFO never overflows by construction; a push to a full FIFO is a design error and must be flagged by a bench assertion.

## Timing
- Request in cycle t → data pushed at end of t+1 → `out_valid` high in t+2. Request-to-output latency is 2 cycles.
- First cycle after `rst` deasserts: request RESET_PC; `out_valid` rises 2 cycles later.
- With `out_ready` held at 1, steady-state throughput is one instruction per cycle (count settles at 1, inflight 1).
- With `out_ready`=0: requests stop once `count + inflight` = DEPTH; `out_inst`/`out_pc` stay stable until popped.
- Redirect in cycle t: `out_valid`=0 in t+1, and the first redirected instruction is valid in t+2.
- Redirect-to-output bubble is 2 cycles.

## Configuration
- `FETCH_PERF_EN` defined:
  - `perf_fetched` increments on every pop.
  - `perf_flushed` adds the number of discarded entries on every redirect: FIFO `count` plus 1 if a response was killed.
  - Both counters reset to 0 and wrap at 2^32.
- Not defined: both ports and counters are absent. All other behaviour is cycle-identical.

## Test plan
- Reset then `out_ready`=1, RAM word k = 0x1000_0000+k → `out_valid` rises 2 cycles after reset release, then (pc 0, 0x1000_0000), (1, 0x1000_0001), … one per cycle.
- `out_ready`=0 for 10 cycles → exactly 4 requests issue, `count`=4, `imem_req`=0 thereafter. Raise `out_ready` → pcs 0..3 pop in order, fetch resumes at 4 with no gaps after refill.
- Redirect to 0x200 while FIFO holds 3 entries and one in flight → `out_valid`=0 next cycle, first output pc 0x200 two cycles after redirect, no stale PCs emitted. With `FETCH_PERF_EN`, `perf_flushed`=4.
- `redirect_pc`=0xFFE, `ADDR_W`=12 → output pcs 0xFFE, 0xFFF, 0x000, 0x001.
- Redirect and `out_ready`=1 asserted in the same cycle as a valid head → that head is not counted (`perf_fetched` unchanged) and the redirect target is the next output.
- `rst` asserted for 1 cycle mid-stream with FIFO full → all outputs return to reset values, and the next output is pc RESET_PC 2 cycles after release.
